// File: rtl/pagerank_pkg.sv
// Shared types and default sizing for the serial PageRank engine and its scatter unit.
package pagerank_pkg;

  typedef logic [31:0] node_id_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SCATTER,
    APPLY,
    CHECK,
    DONE
  } state_e;

  localparam int DEF_NUM_PARTITIONS     = 1;
  localparam int DEF_NODES_IN_PARTITION = 4;
  localparam int DEF_NODES_IN_GRAPH     = 4;
  localparam int DEF_MAX_DEGREE         = 3;
  localparam int DEF_MAX_ITERS          = 100;

endpackage

// File: rtl/pagerank_scatter_unit.sv
// Fans one source node's rank share out to its destination vertices for a single scatter cycle.
module pagerank_scatter_unit
  import pagerank_pkg::*;
#(
  parameter int NODES_IN_GRAPH = DEF_NODES_IN_GRAPH,
  parameter int MAX_DEGREE     = DEF_MAX_DEGREE
) (
  input  logic     src_valid,
  input  real      src_rank,
  input  node_id_t out_degree,
  input  node_id_t dest_id [MAX_DEGREE],
  output real      contrib [NODES_IN_GRAPH]
);

  real share;

  // Slots beyond out_degree and ids outside the graph simply never match a vertex.
  always_comb begin
    share = 0.0;
    for (int v = 0; v < NODES_IN_GRAPH; v++) contrib[v] = 0.0;
    if (src_valid && out_degree != '0) begin
      share = src_rank / real'(out_degree);
      for (int j = 0; j < MAX_DEGREE; j++) begin
        for (int v = 0; v < NODES_IN_GRAPH; v++) begin
          if (node_id_t'(j) < out_degree && dest_id[j] == node_id_t'(v))
            contrib[v] = contrib[v] + share;
        end
      end
    end
  end

endmodule

// File: rtl/pagerank_dmp_serial.sv
// Serial PageRank engine: one stored node scattered per cycle, then a single-cycle apply and check.
module pagerank_dmp_serial
  import pagerank_pkg::*;
#(
  parameter int NUM_PARTITIONS     = DEF_NUM_PARTITIONS,
  parameter int NODES_IN_PARTITION = DEF_NODES_IN_PARTITION,
  parameter int NODES_IN_GRAPH     = DEF_NODES_IN_GRAPH,
  parameter int MAX_DEGREE         = DEF_MAX_DEGREE,
  parameter int MAX_ITERS          = DEF_MAX_ITERS
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     pagerank_enable,
  input  node_id_t source_id  [NUM_PARTITIONS][NODES_IN_PARTITION],
  input  node_id_t out_degree [NUM_PARTITIONS][NODES_IN_PARTITION],
  input  node_id_t dest_id    [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_DEGREE],
  input  real      damping_factor,
  input  real      threshold,
  output real      pagerank [NODES_IN_GRAPH],
  output logic     pagerank_complete
);

  localparam int PW = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;
  localparam int NW = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;

  function automatic real abs_r(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  state_e state, next_state;

  node_id_t src_q [NUM_PARTITIONS][NODES_IN_PARTITION];
  node_id_t deg_q [NUM_PARTITIONS][NODES_IN_PARTITION];
  node_id_t dst_q [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_DEGREE];
  real      d_q, thr_q;

  real          rank_q [NODES_IN_GRAPH];
  real          acc_q  [NODES_IN_GRAPH];
  real          delta_q;
  logic [31:0]  iter_q;
  logic [PW-1:0] part_q;
  logic [NW-1:0] node_q;

  node_id_t cur_src, cur_deg;
  node_id_t cur_dst [MAX_DEGREE];
  logic     src_valid;
  real      src_rank;
  real      contrib  [NODES_IN_GRAPH];
  real      new_rank [NODES_IN_GRAPH];
  real      delta_c;
  logic     last_node;

  always_comb begin
    cur_src = '0;
    cur_deg = '0;
    for (int j = 0; j < MAX_DEGREE; j++) cur_dst[j] = '0;
    for (int p = 0; p < NUM_PARTITIONS; p++) begin
      for (int n = 0; n < NODES_IN_PARTITION; n++) begin
        if (part_q == PW'(p) && node_q == NW'(n)) begin
          cur_src = src_q[p][n];
          cur_deg = deg_q[p][n];
          for (int j = 0; j < MAX_DEGREE; j++) cur_dst[j] = dst_q[p][n][j];
        end
      end
    end
    src_valid = 1'b0;
    src_rank  = 0.0;
    for (int v = 0; v < NODES_IN_GRAPH; v++) begin
      if (cur_src == node_id_t'(v)) begin
        src_valid = 1'b1;
        src_rank  = rank_q[v];
      end
    end
  end

  assign last_node = (part_q == PW'(NUM_PARTITIONS - 1)) &&
                     (node_q == NW'(NODES_IN_PARTITION - 1));

  pagerank_scatter_unit #(
    .NODES_IN_GRAPH (NODES_IN_GRAPH),
    .MAX_DEGREE     (MAX_DEGREE)
  ) u_scatter (
    .src_valid  (src_valid),
    .src_rank   (src_rank),
    .out_degree (cur_deg),
    .dest_id    (cur_dst),
    .contrib    (contrib)
  );

  always_comb begin
    delta_c = 0.0;
    for (int v = 0; v < NODES_IN_GRAPH; v++) begin
      new_rank[v] = (1.0 - d_q) / real'(NODES_IN_GRAPH) + d_q * acc_q[v];
      delta_c     = delta_c + abs_r(new_rank[v] - rank_q[v]);
    end
  end

  // Dropping enable anywhere before DONE abandons the run without touching outputs.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pagerank_enable) next_state = INIT;
      INIT:    next_state = pagerank_enable ? SCATTER : IDLE;
      SCATTER: begin
        if (!pagerank_enable) next_state = IDLE;
        else if (last_node)   next_state = APPLY;
      end
      APPLY:   next_state = pagerank_enable ? CHECK : IDLE;
      CHECK: begin
        if (!pagerank_enable)                                  next_state = IDLE;
        else if (delta_q < thr_q || iter_q == 32'(MAX_ITERS)) next_state = DONE;
        else                                                   next_state = SCATTER;
      end
      DONE:    if (!pagerank_enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n && state == INIT && pagerank_enable) begin
      src_q <= source_id;
      deg_q <= out_degree;
      dst_q <= dest_id;
      d_q   <= damping_factor;
      thr_q <= threshold;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      state             <= IDLE;
      pagerank_complete <= 1'b0;
      iter_q            <= '0;
      part_q            <= '0;
      node_q            <= '0;
      delta_q           <= 0.0;
      for (int v = 0; v < NODES_IN_GRAPH; v++) begin
        rank_q[v]   <= 0.0;
        acc_q[v]    <= 0.0;
        pagerank[v] <= 0.0;
      end
    end else begin
      state             <= next_state;
      pagerank_complete <= (next_state == DONE);
      case (state)
        INIT: if (pagerank_enable) begin
          iter_q <= '0;
          part_q <= '0;
          node_q <= '0;
          for (int v = 0; v < NODES_IN_GRAPH; v++) begin
            rank_q[v] <= 1.0 / real'(NODES_IN_GRAPH);
            acc_q[v]  <= 0.0;
          end
        end
        SCATTER: if (pagerank_enable) begin
          for (int v = 0; v < NODES_IN_GRAPH; v++) acc_q[v] <= acc_q[v] + contrib[v];
          if (node_q == NW'(NODES_IN_PARTITION - 1)) begin
            node_q <= '0;
            part_q <= last_node ? '0 : part_q + PW'(1);
          end else begin
            node_q <= node_q + NW'(1);
          end
        end
        APPLY: if (pagerank_enable) begin
          for (int v = 0; v < NODES_IN_GRAPH; v++) begin
            rank_q[v]   <= new_rank[v];
            pagerank[v] <= new_rank[v];
          end
          delta_q <= delta_c;
          iter_q  <= iter_q + 32'd1;
        end
        CHECK: if (next_state == SCATTER) begin
          part_q <= '0;
          node_q <= '0;
          for (int v = 0; v < NODES_IN_GRAPH; v++) acc_q[v] <= 0.0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_dmp_serial.sv
// Bench for the serial PageRank engine against an edge-list power-iteration reference model.
module tb_pagerank_dmp_serial;

  localparam int P    = 1;
  localparam int N    = 4;
  localparam int G    = 4;
  localparam int D    = 3;
  localparam int MAXI = 100;
  localparam int ITER_CYC = P * N + 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pagerank_enable;
  logic [31:0] source_id  [P][N];
  logic [31:0] out_degree [P][N];
  logic [31:0] dest_id    [P][N][D];
  real         damping_factor;
  real         threshold;
  real         pagerank [G];
  logic        pagerank_complete;

  int  n_vec = 0;
  int  n_err = 0;
  real exp_rank [G];
  int  exp_iters;

  always #5 clock = ~clock;

  pagerank_dmp_serial dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pagerank_enable   (pagerank_enable),
    .source_id         (source_id),
    .out_degree        (out_degree),
    .dest_id           (dest_id),
    .damping_factor    (damping_factor),
    .threshold         (threshold),
    .pagerank          (pagerank),
    .pagerank_complete (pagerank_complete)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic real fabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  // Reference: plain power iteration over the stored edge list.
  function automatic void model_run(input real d, input real thr);
    real acc [G];
    real nr;
    real delta;
    int  k;
    for (int v = 0; v < G; v++) exp_rank[v] = 1.0 / G;
    exp_iters = 0;
    do begin
      for (int v = 0; v < G; v++) acc[v] = 0.0;
      for (int p = 0; p < P; p++)
        for (int n = 0; n < N; n++) begin
          k = (out_degree[p][n] > D) ? D : int'(out_degree[p][n]);
          if (source_id[p][n] < G && out_degree[p][n] != 0)
            for (int j = 0; j < k; j++)
              if (dest_id[p][n][j] < G)
                acc[dest_id[p][n][j]] += exp_rank[source_id[p][n]] / real'(out_degree[p][n]);
        end
      delta = 0.0;
      for (int v = 0; v < G; v++) begin
        nr = (1.0 - d) / G + d * acc[v];
        delta += fabs(nr - exp_rank[v]);
        exp_rank[v] = nr;
      end
      exp_iters++;
    end while (!(delta < thr) && exp_iters < MAXI);
  endfunction

  task automatic load_default();
    int deg [N] = '{2, 1, 3, 1};
    int dst [N][D] = '{'{1, 2, 0}, '{3, 0, 0}, '{0, 1, 3}, '{2, 0, 0}};
    for (int n = 0; n < N; n++) begin
      source_id[0][n]  = n;
      out_degree[0][n] = deg[n];
      for (int j = 0; j < D; j++) dest_id[0][n][j] = dst[n][j];
    end
  endtask

  task automatic run_until_done(output int lat);
    bit seen = 0;
    int i = 0;
    lat = -1;
    pagerank_enable = 1'b1;
    while (!seen && i < 1000) begin
      tick();
      if (pagerank_complete === 1'b1) begin
        seen = 1;
        lat  = i;
      end
      i++;
    end
  endtask

  task automatic stop_run();
    pagerank_enable = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_model(input string tag, input real tol);
    for (int v = 0; v < G; v++) begin
      n_vec++;
      if (!(fabs(pagerank[v] - exp_rank[v]) <= tol)) begin
        n_err++;
        $display("FAIL %s_rank[%0d]: got %.9f want %.9f", tag, v, pagerank[v], exp_rank[v]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    pagerank_enable = 1'b0;
    damping_factor = 0.85;
    threshold = 1e-5;
    load_default();
    repeat (2) tick();
    for (int v = 0; v < G; v++) begin
      n_vec++;
      if (pagerank[v] != 0.0) begin
        n_err++;
        $display("FAIL reset_rank[%0d]: got %f want 0.0", v, pagerank[v]);
      end
    end
    n_vec++;
    if (pagerank_complete !== 1'b0) begin
      n_err++;
      $display("FAIL reset_complete: got %b want 0", pagerank_complete);
    end
    reset_n = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (pagerank_complete !== 1'b0 || pagerank[0] != 0.0) begin
      n_err++;
      $display("FAIL idle_hold: complete %b rank0 %f want 0/0.0", pagerank_complete, pagerank[0]);
    end
  endtask

  task automatic test_first_iteration();
    real fi [G] = '{0.10833333, 0.21458333, 0.35625, 0.32083333};
    load_default();
    damping_factor = 0.85;
    threshold = 1e-5;
    pagerank_enable = 1'b1;
    repeat (7) tick();
    for (int v = 0; v < G; v++) begin
      n_vec++;
      if (!(fabs(pagerank[v] - fi[v]) <= 1e-6)) begin
        n_err++;
        $display("FAIL first_iter_rank[%0d]: got %.8f want %.8f", v, pagerank[v], fi[v]);
      end
    end
    n_vec++;
    if (pagerank_complete !== 1'b0) begin
      n_err++;
      $display("FAIL first_iter_complete: got %b want 0", pagerank_complete);
    end
    stop_run();
  endtask

  task automatic test_convergence();
    real approx [G] = '{0.13867, 0.19761, 0.35708, 0.30664};
    real sum = 0.0;
    int  lat;
    load_default();
    damping_factor = 0.85;
    threshold = 1e-5;
    model_run(0.85, 1e-5);
    run_until_done(lat);
    n_vec++;
    if (lat != 1 + exp_iters * ITER_CYC) begin
      n_err++;
      $display("FAIL conv_latency: got %0d want %0d", lat, 1 + exp_iters * ITER_CYC);
    end
    check_model("conv", 1e-9);
    for (int v = 0; v < G; v++) begin
      sum += pagerank[v];
      n_vec++;
      if (!(fabs(pagerank[v] - approx[v]) <= 1e-3)) begin
        n_err++;
        $display("FAIL conv_approx[%0d]: got %.6f want %.6f", v, pagerank[v], approx[v]);
      end
    end
    n_vec++;
    if (!(fabs(sum - 1.0) <= 1e-6)) begin
      n_err++;
      $display("FAIL conv_sum: got %.9f want 1.0", sum);
    end
    repeat (5) tick();
    n_vec++;
    if (pagerank_complete !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold: got %b want 1", pagerank_complete);
    end
    check_model("done_hold", 1e-9);
    pagerank_enable = 1'b0;
    tick();
    n_vec++;
    if (pagerank_complete !== 1'b0) begin
      n_err++;
      $display("FAIL done_release: got %b want 0", pagerank_complete);
    end
    check_model("release_hold", 1e-9);
    tick();
  endtask

  task automatic test_dangling();
    int lat;
    load_default();
    out_degree[0][3] = 0;
    dest_id[0][0][1] = 7;
    damping_factor = 0.85;
    threshold = 1e-5;
    model_run(0.85, 1e-5);
    run_until_done(lat);
    n_vec++;
    if (lat != 1 + exp_iters * ITER_CYC) begin
      n_err++;
      $display("FAIL dangling_latency: got %0d want %0d", lat, 1 + exp_iters * ITER_CYC);
    end
    check_model("dangling", 1e-9);
    for (int v = 0; v < G; v++) begin
      n_vec++;
      if (pagerank[v] != pagerank[v]) begin
        n_err++;
        $display("FAIL dangling_nan[%0d]: got %f want a number", v, pagerank[v]);
      end
    end
    stop_run();
  endtask

  task automatic test_iter_cap();
    int lat;
    load_default();
    damping_factor = 0.85;
    threshold = 0.0;
    model_run(0.85, 0.0);
    run_until_done(lat);
    n_vec++;
    if (lat != 1 + MAXI * ITER_CYC) begin
      n_err++;
      $display("FAIL cap_latency: got %0d want %0d", lat, 1 + MAXI * ITER_CYC);
    end
    check_model("cap", 1e-9);
    stop_run();
  endtask

  task automatic test_random();
    int  lat;
    int  perm [N];
    int  a, b, t;
    real d;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < N; n++) perm[n] = n;
      for (int s = 0; s < 6; s++) begin
        a = $urandom_range(0, N - 1);
        b = $urandom_range(0, N - 1);
        t = perm[a]; perm[a] = perm[b]; perm[b] = t;
      end
      for (int n = 0; n < N; n++) begin
        source_id[0][n]  = perm[n];
        out_degree[0][n] = $urandom_range(0, 4);
        for (int j = 0; j < D; j++) dest_id[0][n][j] = $urandom_range(0, 5);
      end
      if ($urandom_range(0, 3) == 0) source_id[0][$urandom_range(0, N - 1)] = 5;
      d = 0.5 + real'($urandom_range(0, 45)) / 100.0;
      damping_factor = d;
      threshold = 1e-4;
      model_run(d, 1e-4);
      run_until_done(lat);
      n_vec++;
      if (lat != 1 + exp_iters * ITER_CYC) begin
        n_err++;
        $display("FAIL rand%0d_latency: got %0d want %0d", r, lat, 1 + exp_iters * ITER_CYC);
      end
      check_model($sformatf("rand%0d", r), 1e-7);
      stop_run();
    end
  endtask

  task automatic test_midrun_reset();
    int lat;
    load_default();
    damping_factor = 0.85;
    threshold = 1e-5;
    model_run(0.85, 1e9);
    pagerank_enable = 1'b1;
    repeat (9) tick();
    check_model("pre_reset", 1e-9);
    reset_n = 1'b1;
    pagerank_enable = 1'b0;
    tick();
    for (int v = 0; v < G; v++) begin
      n_vec++;
      if (pagerank[v] != 0.0) begin
        n_err++;
        $display("FAIL midreset_rank[%0d]: got %f want 0.0", v, pagerank[v]);
      end
    end
    n_vec++;
    if (pagerank_complete !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_complete: got %b want 0", pagerank_complete);
    end
    reset_n = 1'b0;
    tick();
    model_run(0.85, 1e-5);
    run_until_done(lat);
    n_vec++;
    if (lat != 1 + exp_iters * ITER_CYC) begin
      n_err++;
      $display("FAIL post_reset_latency: got %0d want %0d", lat, 1 + exp_iters * ITER_CYC);
    end
    stop_run();
  endtask

  task automatic test_abort();
    int lat;
    load_default();
    damping_factor = 0.85;
    threshold = 1e-5;
    model_run(0.85, 1e9);
    pagerank_enable = 1'b1;
    repeat (9) tick();
    pagerank_enable = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (pagerank_complete !== 1'b0) begin
      n_err++;
      $display("FAIL abort_complete: got %b want 0", pagerank_complete);
    end
    check_model("abort_hold", 1e-9);
    model_run(0.85, 1e-5);
    run_until_done(lat);
    n_vec++;
    if (lat != 1 + exp_iters * ITER_CYC) begin
      n_err++;
      $display("FAIL post_abort_latency: got %0d want %0d", lat, 1 + exp_iters * ITER_CYC);
    end
    check_model("post_abort", 1e-9);
    stop_run();
  endtask

  initial begin
    reset_n = 1'b1;
    pagerank_enable = 1'b0;
    test_reset();
    test_first_iteration();
    test_convergence();
    test_dangling();
    test_iter_cap();
    test_random();
    test_midrun_reset();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pagerank_dmp_serial.md
Name: pagerank_dmp_serial

Overview:
- Serial (single-scatter-lane) PageRank engine for a statically partitioned graph.
- Takes per-partition adjacency lists (source id, out-degree, destination list) plus damping factor and convergence threshold.
- Iterates scatter/apply rounds until the L1 change in rank drops below threshold, then raises pagerank_complete.
- Acts as the serial baseline against which the multi-threaded DMP variants are compared.

Parameters:
- NUM_PARTITIONS, 1, number of graph partitions.
- NODES_IN_PARTITION, 4, source nodes stored per partition.
- NODES_IN_GRAPH, 4, total vertices; sizes the pagerank output.
- MAX_DEGREE, 3, destination slots per source node.
- MAX_ITERS, 100, iteration cap if convergence never occurs.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset_n  input  1  synchronous, active-high reset (asserted when 1; name follows codebase convention).
- pagerank_enable  input  1  start/run request; level-sensitive.
- source_id  input  32 x [NUM_PARTITIONS][NODES_IN_PARTITION]  vertex id of each stored node.
- out_degree  input  32 x [NUM_PARTITIONS][NODES_IN_PARTITION]  valid destination count per node.
- dest_id  input  32 x [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_DEGREE]  destination vertex ids.
- damping_factor  input  real  damping factor d (e.g. 0.85).
- threshold  input  real  convergence bound on sum of |delta|.
- pagerank  output  real x [NODES_IN_GRAPH]  current rank per vertex.
- pagerank_complete  output  1  convergence/done flag.

Behaviour:
- Reset: state=IDLE, pagerank[*]=0.0, pagerank_complete=0, accumulators=0, iteration count=0. Reset has priority over every other event.
- FSM states: IDLE, INIT, SCATTER, APPLY, CHECK, DONE.
- IDLE -> INIT when pagerank_enable=1.
- INIT (1 cycle):
  - latch all graph inputs, damping_factor and threshold;
  - set rank[v]=1.0/NODES_IN_GRAPH;
  - clear accumulators and node cursor.
- SCATTER (one stored node per cycle; partitions in order, nodes in index order; NUM_PARTITIONS*NODES_IN_PARTITION cycles):
  - for node u with k=min(out_degree,MAX_DEGREE)>0, add rank[source_id]/out_degree to acc[dest_id[j]] for j<k;
  - duplicate destinations add twice;
  - dest ids >= NODES_IN_GRAPH are ignored;
  - out_degree 0 (dangling) contributes nothing;
  - after the last node -> APPLY.
- APPLY (1 cycle):
  - new[v]=(1-d)/NODES_IN_GRAPH + d*acc[v] for all v;
  - delta = sum |new[v]-rank[v]|;
  - rank<=new; pagerank output <= new; iteration count++.
- CHECK (1 cycle):
  - if delta < threshold or iteration count == MAX_ITERS -> DONE;
  - else clear accumulators and cursor -> SCATTER.
- DONE: pagerank_complete=1, pagerank held. Stays until pagerank_enable=0, then -> IDLE with complete=0 and ranks held.
- pagerank_enable dropped in INIT/SCATTER/APPLY/CHECK: abort to IDLE. Outputs keep their last APPLY values and complete stays 0.
- Latency: 1 + iters*(NUM_PARTITIONS*NODES_IN_PARTITION + 2) cycles from the first enable-sampled edge to complete. With defaults, 6 cycles per iteration.
- Inputs changing after INIT are ignored until the next run.

Decomposition:
- Shared package pagerank_pkg holds:
  - the state enum (IDLE..DONE);
  - the node-id typedef (32-bit);
  - default constants for the parameters.
- One natural sub-module, pagerank_scatter_unit: per-cycle contribution computation (rank/out_degree fan-out to MAX_DEGREE accumulator addresses with validity masking).
- The FSM and apply/check logic live in the top.

Test Plan:
- Reset: reset_n=1 for 2 cycles -> pagerank all 0.0, complete=0, state IDLE. Release with enable=0 -> stays IDLE.
- First iteration on the 4-node graph, d=0.85:
  - source_id {0,1,2,3}, out_degree {2,1,3,1}, dest {{1,2,0},{3,0,0},{0,1,3},{2,0,0}};
  - after the first APPLY (cycle 6), pagerank = {0.108333, 0.214583, 0.356250, 0.320833} (±1e-6).
- Convergence, same graph, threshold 1e-5:
  - complete rises with pagerank ≈ {0.13867, 0.19761, 0.35708, 0.30664} (±1e-3), sum ≈ 1.0;
  - complete held until enable=0.
- Dangling and out-of-range dests: node 3 out_degree 0 and a dest id of 7 -> no contribution from either; ranks still computed with no X/NaN.
- Iteration cap: threshold 0.0 -> complete after exactly MAX_ITERS iterations (cycle count per the latency formula).
- Mid-run events:
  - reset_n pulsed during SCATTER -> outputs 0, IDLE next cycle;
  - enable dropped during SCATTER -> IDLE, complete stays 0.
